// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for MIPS div/divu. The result is
// {remainder, quotient} and stays valid while ready_o is high.
module div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_t;

  localparam logic [5:0]       LAST = 6'(WIDTH);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t             state;
  logic [5:0]         cnt;
  logic [2*WIDTH:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH:0]     tmp;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic               neg1;
  logic               neg2;

  always_comb begin
    neg1 = signed_div_i && opdata1_i[WIDTH-1];
    neg2 = signed_div_i && opdata2_i[WIDTH-1];
    abs1 = neg1 ? (~opdata1_i + ONE) : opdata1_i;
    abs2 = neg2 ? (~opdata2_i + ONE) : opdata2_i;
    tmp  = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
  end

  // Partial remainder lives in dividend[2W:W+1], quotient bits shift in at [0].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state    <= ON;
              cnt      <= '0;
              dividend <= {{WIDTH{1'b0}}, abs1, 1'b0};
              divisor  <= abs2;
            end
          end
        end
        BYZERO: begin
          dividend <= '0;
          state    <= END;
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt != LAST) begin
            if (tmp[WIDTH])
              dividend <= dividend << 1;
            else
              dividend <= {tmp[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            if (neg1 ^ neg2)
              dividend[WIDTH-1:0] <= ~dividend[WIDTH-1:0] + ONE;
            if (neg1)
              dividend[2*WIDTH:WIDTH+1] <= ~dividend[2*WIDTH:WIDTH+1] + ONE;
            state <= END;
            cnt   <= '0;
          end
        end
        END: begin
          if (start_i) begin
            result_o <= {dividend[2*WIDTH:WIDTH+1], dividend[WIDTH-1:0]};
            ready_o  <= 1'b1;
          end else begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for div: latency, results, annul, async reset and
// back-to-back start handling against hand-computed values.
module tb_div;
  localparam int unsigned W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             signed_div_i;
  logic [W-1:0]     opdata1_i;
  logic [W-1:0]     opdata2_i;
  logic             start_i;
  logic             annul_i;
  logic [2*W-1:0]   result_o;
  logic             ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
  endtask

  // Edge index 0 is the edge that samples start_i in FREE.
  task automatic wait_ready(input string tag, input int lat, input logic [63:0] exp);
    int edges = -1;
    bit seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready_o) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " result"}, result_o, exp);
  endtask

  task automatic drop_start(input string tag);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready after drop"}, 64'(ready_o), 64'd0);
    check({tag, " result after drop"}, result_o, 64'd0);
  endtask

  initial begin
    bit seen;
    logic [63:0] held;
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    #12;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    launch(32'd100, 32'd7, 1'b0);
    wait_ready("divu 100/7", 34, 64'h00000002_0000000E);
    drop_start("divu 100/7");

    launch(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_ready("div -7/2", 34, 64'hFFFFFFFF_FFFFFFFD);
    drop_start("div -7/2");

    launch(32'd7, 32'hFFFFFFFE, 1'b1);
    wait_ready("div 7/-2", 34, 64'h00000001_FFFFFFFD);
    drop_start("div 7/-2");

    launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_ready("div overflow", 34, 64'h00000000_80000000);
    drop_start("div overflow");

    launch(32'h1234, 32'd0, 1'b0);
    wait_ready("divu by zero", 2, 64'd0);
    drop_start("divu by zero");

    launch(32'h1234, 32'd0, 1'b1);
    wait_ready("div by zero", 2, 64'd0);
    drop_start("div by zero");

    // Annul during ON, then start+annul together must keep the FSM idle.
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check("annul no ready", 64'(seen), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    launch(32'd9, 32'd3, 1'b0);
    wait_ready("divu 9/3 after annul", 34, 64'h00000000_00000003);
    drop_start("divu 9/3");

    // Async reset mid-division, then a clean rerun.
    launch(32'hFFFFFFFF, 32'd1, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset in ON ready", 64'(ready_o), 64'd0);
    check("reset in ON result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    launch(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_ready("divu max/1", 34, 64'h00000000_FFFFFFFF);

    // Start held across END keeps the result stable.
    held = result_o;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold ready", 64'(ready_o), 64'd1);
      check("hold result", result_o, held);
    end
    drop_start("one-cycle low");
    launch(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_ready("back-to-back", 34, 64'h00000000_FFFFFFFF);

    // Async reset while the result is presented clears it without an edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset in END ready", 64'(ready_o), 64'd0);
    check("reset in END result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
